// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt-request front end.
// Sized to match the external 8-bit priority encoder.
package irq_pkg;
    localparam int N_IRQ  = 8;
    localparam int IDX_W  = 3;
    localparam int MISS_W = 8;
    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser followed by a rising-edge detector.
// The pulse is one cycle wide; a level held high yields a single pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~sync_d;
endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt front end: synchronise, edge-detect and hold requests, present them
// to the external priority encoder, and hand the encoded index to a consumer.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int N           = N_IRQ,
    parameter int IDXW        = IDX_W,
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      irq_in,
    input  logic [N-1:0]      mask,
    output logic [N-1:0]      pend_vec,
    input  logic [IDXW-1:0]   enc_idx,
    output logic              irq_valid,
    output logic [IDXW-1:0]   irq_idx,
    input  logic              irq_ack,
    input  logic              clr_miss,
    output logic [MISS_W-1:0] miss_cnt,
    output state_t            dbg_state
);
    localparam logic [MISS_W-1:0] CNT_MAX = {MISS_W{1'b1}};
    localparam logic [N-1:0]      ONE     = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] edge_vec;
    logic [N-1:0] pending;
    logic [N-1:0] clr_vec;
    logic [N-1:0] miss_vec;
    logic         handshake;
    state_t       state;

    for (genvar i = 0; i < N; i++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (irq_in[i]),
            .pulse (edge_vec[i])
        );
    end

    // Handshake: irq_valid/irq_idx are held from capture until the edge where
    // irq_valid && irq_ack, which completes the transfer; ack alone does nothing.
    assign handshake = (state == PRESENT) && irq_ack;
    assign clr_vec   = handshake ? (ONE << irq_idx) : '0;
    assign miss_vec  = edge_vec & pending & ~clr_vec;
    assign pend_vec  = pending & ~mask;
    assign irq_valid = (state == PRESENT);
    assign dbg_state = state;

    // A new edge overrides a same-cycle clear so the request is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr_vec) | edge_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend_vec) begin
                        irq_idx <= enc_idx;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              miss_cnt <= '0;
        else if (clr_miss)                       miss_cnt <= '0;
        else if (|miss_vec && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
    end
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Bench for irq_pend_ctrl with a behavioural encoder and a request-level model.
module tb_irq_pend_ctrl;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = '0;
    logic [7:0] mask = '0;
    logic [7:0] pend_vec;
    logic [2:0] enc_idx;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic       irq_ack = 1'b0;
    logic       clr_miss = 1'b0;
    logic [7:0] miss_cnt;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] hq[$];
    logic [7:0] m_pend;
    logic       m_off;
    logic [2:0] m_idx;
    logic [7:0] m_miss;

    always #5 clk = ~clk;

    irq_pend_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .pend_vec(pend_vec),
        .enc_idx(enc_idx), .irq_valid(irq_valid), .irq_idx(irq_idx), .irq_ack(irq_ack),
        .clr_miss(clr_miss), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
    );

    // External priority encoder: highest set bit wins
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < 8; i++) if (pend_vec[i]) enc_idx = 3'(i);
    end

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        int n;
        n = int'(v) + 1;
        return 3'($clog2(n) - 1);
    endfunction

    function automatic logic [7:0] exp_pv();
        return m_pend & ~mask;
    endfunction

    task automatic model_reset();
        hq = '{8'h00, 8'h00, 8'h00};
        m_pend = '0; m_off = 1'b0; m_idx = '0; m_miss = '0;
    endtask

    // A request becomes pending two edges after irq_in is first sampled high.
    task automatic model_step();
        logic [7:0] req, clr, mis, pv;
        req = hq[1] & ~hq[0];
        hq.push_back(irq_in);
        void'(hq.pop_front());
        clr = (m_off && irq_ack) ? (8'h01 << m_idx) : 8'h00;
        mis = req & m_pend & ~clr;
        if (clr_miss) m_miss = '0;
        else if (mis != 0 && m_miss != 8'd255) m_miss = m_miss + 8'd1;
        pv = m_pend & ~mask;
        if (m_off) begin
            if (irq_ack) m_off = 1'b0;
        end else if (pv != 0) begin
            m_off = 1'b1;
            m_idx = top_bit(pv);
        end
        m_pend = (m_pend & ~clr) | req;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++; if (pend_vec !== 8'h00) begin n_fail++; $display("FAIL reset_pend_vec: got %h exp 00", pend_vec); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_irq_valid: got %b exp 0", irq_valid); end
        n_cmp++; if (irq_idx !== 3'd0) begin n_fail++; $display("FAIL reset_irq_idx: got %0d exp 0", irq_idx); end
        n_cmp++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_miss_cnt: got %0d exp 0", miss_cnt); end
        n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
    endtask

    task automatic test_single();
        irq_in = 8'h08;
        cycle(); cycle();
        n_cmp++; if (pend_vec !== 8'h00) begin n_fail++; $display("FAIL single_pend_e1: got %h exp 00", pend_vec); end
        cycle();
        n_cmp++; if (pend_vec !== 8'h08) begin n_fail++; $display("FAIL single_pend_e2: got %h exp 08", pend_vec); end
        n_cmp++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_e2: got %b exp 0", irq_valid); end
        cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd3) begin n_fail++; $display("FAIL single_offer_e3: got v=%b idx=%0d exp v=1 idx=3", irq_valid, irq_idx); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        n_cmp++; if (pend_vec !== 8'h00 || irq_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack: got pv=%h v=%b exp pv=00 v=0", pend_vec, irq_valid); end
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_priority();
        irq_in = 8'h42; drain(4);
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd6) begin n_fail++; $display("FAIL prio_first: got v=%b idx=%0d exp v=1 idx=6", irq_valid, irq_idx); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        n_cmp++; if (irq_valid !== 1'b0 || pend_vec !== 8'h02) begin n_fail++; $display("FAIL prio_idle_gap: got v=%b pv=%h exp v=0 pv=02", irq_valid, pend_vec); end
        cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd1) begin n_fail++; $display("FAIL prio_second: got v=%b idx=%0d exp v=1 idx=1", irq_valid, irq_idx); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        n_cmp++; if (pend_vec !== 8'h00 || irq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_done: got pv=%h v=%b exp pv=00 v=0", pend_vec, irq_valid); end
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_mask();
        mask = 8'h40; irq_in = 8'h40; drain(5);
        n_cmp++; if (pend_vec !== 8'h00 || irq_valid !== 1'b0) begin n_fail++; $display("FAIL mask_hidden: got pv=%h v=%b exp pv=00 v=0", pend_vec, irq_valid); end
        mask = 8'h00; #1;
        n_cmp++; if (pend_vec !== 8'h40) begin n_fail++; $display("FAIL mask_comb: got %h exp 40", pend_vec); end
        cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd6) begin n_fail++; $display("FAIL mask_release: got v=%b idx=%0d exp v=1 idx=6", irq_valid, irq_idx); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_committed();
        irq_in = 8'h04; drain(4);
        irq_in = 8'h84;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd2) begin n_fail++; $display("FAIL commit_hold: got v=%b idx=%0d exp v=1 idx=2", irq_valid, irq_idx); end
        end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        n_cmp++; if (irq_valid !== 1'b0 || pend_vec !== 8'h80) begin n_fail++; $display("FAIL commit_gap: got v=%b pv=%h exp v=0 pv=80", irq_valid, pend_vec); end
        cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd7) begin n_fail++; $display("FAIL commit_next: got v=%b idx=%0d exp v=1 idx=7", irq_valid, irq_idx); end
        mask = 8'h80; cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd7 || pend_vec !== 8'h00) begin n_fail++; $display("FAIL commit_masked: got v=%b idx=%0d pv=%h exp v=1 idx=7 pv=00", irq_valid, irq_idx, pend_vec); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        mask = 8'h00; #1;
        n_cmp++; if (pend_vec !== 8'h00 || irq_valid !== 1'b0) begin n_fail++; $display("FAIL commit_masked_ack: got pv=%h v=%b exp pv=00 v=0", pend_vec, irq_valid); end
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_miss();
        irq_in = 8'h10; drain(4);
        for (int k = 0; k < 300; k++) begin
            irq_in[4] = 1'b0; cycle();
            irq_in[4] = 1'b1; cycle();
        end
        drain(3);
        n_cmp++; if (miss_cnt !== 8'd255 || miss_cnt !== m_miss) begin n_fail++; $display("FAIL miss_saturate: got %0d exp 255 (model %0d)", miss_cnt, m_miss); end
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd4) begin n_fail++; $display("FAIL miss_offer_kept: got v=%b idx=%0d exp v=1 idx=4", irq_valid, irq_idx); end
        irq_in[4] = 1'b0; cycle();
        irq_in[4] = 1'b1; cycle(); cycle();
        clr_miss = 1'b1; cycle(); clr_miss = 1'b0;
        n_cmp++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL miss_clear_wins: got %0d exp 0", miss_cnt); end
        cycle();
        n_cmp++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL miss_clear_hold: got %0d exp 0", miss_cnt); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_collision_reset();
        logic [7:0] miss_before;
        irq_in = 8'h20; drain(4);
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd5) begin n_fail++; $display("FAIL coll_offer: got v=%b idx=%0d exp v=1 idx=5", irq_valid, irq_idx); end
        miss_before = m_miss;
        irq_in = 8'h00; cycle();
        irq_in = 8'h20; cycle(); cycle();
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        n_cmp++; if (pend_vec !== 8'h20 || irq_valid !== 1'b0) begin n_fail++; $display("FAIL coll_set_wins: got pv=%h v=%b exp pv=20 v=0", pend_vec, irq_valid); end
        n_cmp++; if (miss_cnt !== miss_before) begin n_fail++; $display("FAIL coll_no_miss: got %0d exp %0d", miss_cnt, miss_before); end
        cycle();
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd5) begin n_fail++; $display("FAIL coll_reoffer: got v=%b idx=%0d exp v=1 idx=5", irq_valid, irq_idx); end
        #2 rst_n = 1'b0; #1;
        n_cmp++; if (irq_valid !== 1'b0 || pend_vec !== 8'h00) begin n_fail++; $display("FAIL async_reset: got v=%b pv=%h exp v=0 pv=00", irq_valid, pend_vec); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drain(4);
        n_cmp++; if (irq_valid !== 1'b1 || irq_idx !== 3'd5) begin n_fail++; $display("FAIL held_through_reset: got v=%b idx=%0d exp v=1 idx=5", irq_valid, irq_idx); end
        irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
        drain(6);
        n_cmp++; if (irq_valid !== 1'b0 || pend_vec !== 8'h00) begin n_fail++; $display("FAIL held_single_edge: got v=%b pv=%h exp v=0 pv=00", irq_valid, pend_vec); end
        irq_in = 8'h00; drain(4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom & $urandom);
            irq_ack  = ($urandom_range(0, 2) == 0);
            clr_miss = ($urandom_range(0, 31) == 0);
            cycle();
            n_cmp++; if (pend_vec !== exp_pv()) begin n_fail++; $display("FAIL rand_pend_vec c=%0d: got %h exp %h", c, pend_vec, exp_pv()); end
            n_cmp++; if (irq_valid !== m_off) begin n_fail++; $display("FAIL rand_irq_valid c=%0d: got %b exp %b", c, irq_valid, m_off); end
            if (m_off) begin
                n_cmp++; if (irq_idx !== m_idx) begin n_fail++; $display("FAIL rand_irq_idx c=%0d: got %0d exp %0d", c, irq_idx, m_idx); end
            end
            n_cmp++; if (miss_cnt !== m_miss) begin n_fail++; $display("FAIL rand_miss_cnt c=%0d: got %0d exp %0d", c, miss_cnt, m_miss); end
        end
        irq_ack = 1'b0; clr_miss = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_committed();
        test_miss();
        test_collision_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_pend_ctrl.md
Name: irq_pend_ctrl

Overview:
- Interrupt-request front end that sits directly upstream of the 8-bit priority encoder and feeds its input vector.
- Synchronises 8 asynchronous request lines, detects rising edges and holds them in a pending register, then presents the masked pending vector to the encoder.
- Samples the encoder's 3-bit code back, latches it, and offers it to a consumer through a valid/ack handshake.
- Clears the serviced pending bit on ack and counts requests lost because a line was already pending.

Parameters:
N, 8, number of request lines; fixed at 8 to match the encoder width.
IDXW, 3, index width, equal to $clog2(N).
SYNC_STAGES, 2, synchroniser depth per line; minimum 2.
MISS_W, 8, width of the saturating miss counter.

Ports:
clk  input  1  clock; all flops rise-edge.
rst_n  input  1  asynchronous active-low reset.
irq_in  input  N  asynchronous request lines; a rising edge is one request.
mask  input  N  1 = line masked from presentation; pending still records the request.
pend_vec  output  N  pending & ~mask, driven to the encoder input y.
enc_idx  input  IDXW  encoder output a; ignored when pend_vec == 0, since it is z then.
irq_valid  output  1  a serviced index is offered.
irq_idx  output  IDXW  latched index; stable while irq_valid is high.
irq_ack  input  1  consumer accepts; the handshake completes on the clock edge where irq_valid && irq_ack.
clr_miss  input  1  synchronous clear of miss_cnt.
miss_cnt  output  MISS_W  count of edges that hit an already-pending line; saturates.

Behaviour:
- Reset (async, rst_n low):
  - All synchroniser and edge-detect flops = 0, pending = 0, state = IDLE.
  - irq_valid = 0, irq_idx = 0, miss_cnt = 0, therefore pend_vec = 0.
  - A line held high through reset release registers exactly one edge.
- Edge detection: edge[i] = sync_out[i] & ~sync_d[i]. A line held high produces no further requests.
- Pending register:
  - pending[i] sets on edge[i].
  - pending[i] clears on handshake completion when irq_idx == i.
  - If the set and the clear land in the same cycle, set wins and the new request is retained.
- pend_vec is combinational from the pending and mask inputs; mask changes take effect in the same cycle.
- FSM:
  - IDLE: irq_valid = 0. If |pend_vec, capture irq_idx <= enc_idx and go to PRESENT; otherwise stay.
  - PRESENT: irq_valid = 1 and irq_idx held. On irq_ack, clear pending[irq_idx] and go to IDLE; otherwise stay.
  - irq_ack in IDLE has no effect.
  - After an ack, IDLE re-evaluates from the updated pend_vec. Back-to-back service therefore gives one idle cycle between valids.
- Committed offer: once in PRESENT, mask changes or new higher-priority edges do not alter irq_idx or drop irq_valid.
  - If the offered line becomes masked, ack still clears its pending bit.
- Latency (SYNC_STAGES = 2), taking the edge that first samples irq_in high as edge 0:
  - pend_vec bit visible after edge 2.
  - irq_valid high after edge 3, when in IDLE with no prior pending.
- Miss counter:
  - Increments when edge[i] && pending[i] && !(clearing i this cycle).
  - Multiple simultaneous misses add 1 in total per cycle.
  - Saturates at 2^MISS_W - 1.
  - clr_miss zeros the counter and wins over a same-cycle increment.
- Reset mid-handshake: irq_valid drops immediately (async) and all pending is lost.

Decomposition:
- Package irq_pkg holds:
  - constants N_IRQ = 8 and IDX_W = 3;
  - state enum state_t {IDLE, PRESENT};
  - MISS_MAX.
- Sub-module irq_sync_edge (one instance per line via generate):
  - SYNC_STAGES flop chain plus a delayed copy, outputting a 1-cycle edge pulse;
  - same clk and rst_n.
- The priority encoder itself stays external; the bench instantiates it between pend_vec and enc_idx.

Test Plan:
1. Single request: reset, then raise irq_in[3] before edge 0. Expect pend_vec = 8'h08 after edge 2, irq_valid = 1 with irq_idx = 3 after edge 3. Pulse irq_ack to get pend_vec = 0 and irq_valid = 0 on the next edge.
2. Priority and re-service: raise irq_in[1] and irq_in[6] together. Expect irq_idx = 6 first; after ack, one idle cycle, then irq_idx = 1; after a second ack, pend_vec = 0.
3. Mask: set mask = 8'h40 and raise irq_in[6]. Expect pending set but pend_vec = 0 and irq_valid stays 0. Clear the mask to get irq_valid with irq_idx = 6 one edge later.
4. Committed offer: while PRESENT with irq_idx = 2, raise irq_in[7]. Expect irq_idx to stay 2 until ack, then irq_idx = 7.
5. Miss and saturation:
   - With line 4 pending and not acked, toggle irq_in[4] 300 times. Expect miss_cnt = 255.
   - Assert clr_miss in the same cycle as a further miss. Expect miss_cnt = 0.
6. Set/clear collision and reset: have a new edge on line 5 arrive in the ack cycle of irq_idx = 5. Expect pending[5] to remain set and a second offer of 5. Then assert rst_n low mid-PRESENT to get irq_valid = 0 and pend_vec = 0 asynchronously.
